// File: rtl/aes_sbox_pipe.sv
// aes_sbox_pipe: 3-stage valid/ready AES SubBytes/InvSubBytes unit using tower-field GF(2^8) inversion
module aes_sbox_pipe #(
  parameter int LANES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_mode,
  input  logic [8*LANES-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_mode,
  output logic [8*LANES-1:0] out_data
);
  function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
    return {(a[1] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[1]), (a[1] & b[1]) ^ (a[0] & b[0])};
  endfunction
  function automatic logic [1:0] gf4_scl(input logic [1:0] a);
    return {a[1] ^ a[0], a[1]};
  endfunction
  function automatic logic [1:0] gf4_sq_scl(input logic [1:0] a);
    return {a[0], a[1]};
  endfunction
  function automatic logic [1:0] gf4_inv(input logic [1:0] a);
    return {a[1], a[1] ^ a[0]};
  endfunction
  function automatic logic [3:0] gf16_mul(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] p;
    p = gf4_mul(a[1:0], b[1:0]);
    return {gf4_mul(a[3:2] ^ a[1:0], b[3:2] ^ b[1:0]) ^ p, gf4_scl(gf4_mul(a[3:2], b[3:2])) ^ p};
  endfunction
  function automatic logic [3:0] gf16_inv(input logic [3:0] a);
    logic [1:0] di;
    di = gf4_inv(gf4_sq_scl(a[3:2]) ^ gf4_mul(a[1:0], a[3:2] ^ a[1:0]));
    return {gf4_mul(a[3:2], di), gf4_mul(a[3:2] ^ a[1:0], di)};
  endfunction
  // Top-level constant: any GF(16) element outside the image of y^2+y keeps Y^2+Y+nu irreducible.
  function automatic logic [3:0] find_nu();
    logic [15:0] hit;
    logic [3:0]  r;
    hit = '0;
    r = '0;
    for (int y = 0; y < 16; y++) hit[gf16_mul(4'(y), 4'(y)) ^ 4'(y)] = 1'b1;
    for (int n = 15; n > 0; n--) if (!hit[n]) r = 4'(n);
    return r;
  endfunction
  localparam logic [3:0] NU = find_nu();
  function automatic logic [3:0] gf16_sq_scl(input logic [3:0] a);
    return gf16_mul(NU, gf16_mul(a, a));
  endfunction
  function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] e;
    e = gf16_mul(NU, gf16_mul(a[7:4] ^ a[3:0], b[7:4] ^ b[3:0]));
    return {gf16_mul(a[7:4], b[7:4]) ^ e, gf16_mul(a[3:0], b[3:0]) ^ e};
  endfunction
  function automatic logic [7:0] lin(input logic [63:0] m, input logic [7:0] x);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r ^= x[i] ? m[8*i+:8] : 8'h00;
    return r;
  endfunction
  // Basis change: columns are powers of a tower-field root of x^8+x^4+x^3+x+1.
  function automatic logic [63:0] build_fwd();
    logic [7:0]  beta, x2, x4, x8;
    logic        found;
    logic [63:0] m;
    beta = '0;
    found = 1'b0;
    for (int c = 2; c < 256 && !found; c++) begin
      x2 = gf256_mul(8'(c), 8'(c));
      x4 = gf256_mul(x2, x2);
      x8 = gf256_mul(x4, x4);
      if ((x8 ^ x4 ^ gf256_mul(x2, 8'(c)) ^ 8'(c) ^ 8'h11) == 8'h00) begin
        beta = 8'(c);
        found = 1'b1;
      end
    end
    m = '0;
    m[7:0] = 8'h11;
    for (int i = 1; i < 8; i++) m[8*i+:8] = gf256_mul(m[8*(i-1)+:8], beta);
    return m;
  endfunction
  function automatic logic [63:0] build_inv(input logic [63:0] f);
    logic [63:0] m;
    logic [7:0]  t;
    m = '0;
    for (int s = 0; s < 256; s++) begin
      t = lin(f, 8'(s));
      for (int j = 0; j < 8; j++) if (t == 8'(1 << j)) m[8*j+:8] = 8'(s);
    end
    return m;
  endfunction
  localparam logic [63:0] TO_T = build_fwd();
  localparam logic [63:0] TO_S = build_inv(TO_T);
  function automatic logic [7:0] aff(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction
  function automatic logic [7:0] inv_aff(input logic [7:0] y);
    return {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
  endfunction
  logic                 s1_v_q, s1_m_q, s2_v_q, s2_m_q, out_v_q, out_m_q;
  logic [8*LANES-1:0]   s1_hl_q, s1_hl_d, s2_hl_q, out_q, out_d;
  logic [4*LANES-1:0]   s1_d_q, s1_d_d, s2_inv_q, s2_inv_d;
  logic                 en1, en2, en3;
  // Backpressure chain: a stage may load when it is empty or its contents move on this cycle.
  always_comb begin
    en3 = !out_v_q | out_ready;
    en2 = !s2_v_q | en3;
    en1 = !s1_v_q | en2;
  end
  // Per-lane datapath: S1 basis map + norm, S2 GF(16) inverse, S3 recombine + back-map + affine.
  always_comb begin
    logic [7:0] t, b;
    t = '0;
    b = '0;
    s1_hl_d = '0;
    s1_d_d = '0;
    s2_inv_d = '0;
    out_d = '0;
    for (int i = 0; i < LANES; i++) begin
      t = lin(TO_T, in_mode ? inv_aff(in_data[8*i+:8]) : in_data[8*i+:8]);
      s1_hl_d[8*i+:8] = t;
      s1_d_d[4*i+:4] = gf16_sq_scl(t[7:4] ^ t[3:0]) ^ gf16_mul(t[7:4], t[3:0]);
      s2_inv_d[4*i+:4] = gf16_inv(s1_d_q[4*i+:4]);
      b = lin(TO_S, {gf16_mul(s2_inv_q[4*i+:4], s2_hl_q[8*i+:4]), gf16_mul(s2_inv_q[4*i+:4], s2_hl_q[8*i+4+:4])});
      out_d[8*i+:8] = s2_m_q ? b : aff(b);
    end
  end
  // Pipeline registers; data only moves alongside a valid word so stalled outputs hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;
      s1_m_q <= 1'b0;
      s1_hl_q <= '0;
      s1_d_q <= '0;
      s2_v_q <= 1'b0;
      s2_m_q <= 1'b0;
      s2_hl_q <= '0;
      s2_inv_q <= '0;
      out_v_q <= 1'b0;
      out_m_q <= 1'b0;
      out_q <= '0;
    end else begin
      if (en1) s1_v_q <= in_valid;
      if (en2) s2_v_q <= s1_v_q;
      if (en3) out_v_q <= s2_v_q;
      if (en1 & in_valid) begin
        s1_m_q <= in_mode;
        s1_hl_q <= s1_hl_d;
        s1_d_q <= s1_d_d;
      end
      if (en2 & s1_v_q) begin
        s2_m_q <= s1_m_q;
        s2_hl_q <= s1_hl_q;
        s2_inv_q <= s2_inv_d;
      end
      if (en3 & s2_v_q) begin
        out_m_q <= s2_m_q;
        out_q <= out_d;
      end
    end
  end
  assign in_ready = en1;
  assign out_valid = out_v_q;
  assign out_mode = out_m_q;
  assign out_data = out_q;
endmodule

// File: tb/tb_aes_sbox_pipe.sv
// tb_aes_sbox_pipe: vector table + scoreboard bench against a plain GF(2^8) S-box model
module tb_aes_sbox_pipe;
  localparam int LANES = 4;
  localparam int W = 8 * LANES;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_mode = 1'b0, out_ready = 1'b1;
  logic [W-1:0] in_data = '0, exp_in = '0;
  logic in_ready, out_valid, out_mode;
  logic [W-1:0] out_data;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  bit chk_lat = 1'b0;
  typedef struct {logic [W-1:0] data; logic mode; int cyc;} sb_t;
  typedef struct {logic [W-1:0] din; logic mode; logic [W-1:0] exp;} vec_t;
  sb_t sb[$];
  sb_t e_q;
  vec_t tbl[7];
  logic [7:0] sbox[256], isbox[256];
  logic st_q = 1'b0, st_m = 1'b0;
  logic [W-1:0] st_d = '0;

  aes_sbox_pipe #(.LANES(LANES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_mode(out_mode),
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) r ^= a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return r;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r;
  endfunction

  function automatic logic [7:0] faff(input logic [7:0] b);
    logic [7:0] c, s;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      s[i] = b[i] ^ b[(i+4)%8] ^ b[(i+5)%8] ^ b[(i+6)%8] ^ b[(i+7)%8] ^ c[i];
    return s;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Scoreboard monitor: samples at negedge, i.e. what will transfer at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) st_q = 1'b0;
    else begin
      if (st_q) check("stall_hold", {out_valid, out_mode, out_data}, {1'b1, st_m, st_d});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got %0h with nothing outstanding", out_data);
        end else begin
          e_q = sb.pop_front();
          check("out_data", out_data, e_q.data);
          check("out_mode", out_mode, e_q.mode);
          if (chk_lat) check("latency", cyc - e_q.cyc, 3);
        end
      end
      if (in_valid && in_ready) sb.push_back('{exp_in, in_mode, cyc});
      st_q = out_valid & !out_ready;
      st_d = out_data;
      st_m = out_mode;
    end
  end

  task automatic send(input logic [W-1:0] d, input logic m, input logic [W-1:0] e);
    int n;
    n = 0;
    in_data = d;
    in_mode = m;
    exp_in = e;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout: in_ready stayed %0b, required 1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("drain_outstanding", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic m);
    logic [W-1:0] r;
    for (int i = 0; i < LANES; i++) r[8*i+:8] = m ? isbox[d[8*i+:8]] : sbox[d[8*i+:8]];
    return r;
  endfunction

  initial begin
    for (int x = 0; x < 256; x++) begin
      sbox[x] = faff(ginv(8'(x)));
      isbox[sbox[x]] = 8'(x);
    end
    tbl[0] = '{32'hFF015300, 1'b0, 32'h167CED63};
    tbl[1] = '{32'h167CED63, 1'b1, 32'hFF015300};
    tbl[2] = '{32'h00000000, 1'b0, 32'h63636363};
    tbl[3] = '{32'h01020304, 1'b0, 32'h7C777BF2};
    tbl[4] = '{32'h10111213, 1'b0, 32'hCA82C97D};
    tbl[5] = '{32'h00010203, 1'b1, 32'h52096AD5};
    tbl[6] = '{32'h63636363, 1'b1, 32'h00000000};

    in_valid = 1'b1;
    in_data = 32'hFF015300;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_mode", out_mode, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    chk_lat = 1'b1;
    for (int i = 0; i < 7; i++) begin
      send(tbl[i].din, tbl[i].mode, tbl[i].exp);
      drain();
    end
    for (int i = 0; i < 7; i++) send(tbl[i].din, tbl[i].mode, tbl[i].exp);
    drain();

    for (int k = 0; k < 512; k++) begin
      logic [7:0] b;
      b = 8'(k >> 1);
      send({LANES{b}}, k[0], {LANES{k[0] ? isbox[b] : sbox[b]}});
    end
    drain();
    chk_lat = 1'b0;

    fork
      for (int k = 0; k < 10; k++) begin
        logic [W-1:0] d;
        d = W'(k * 32'h11223344 + 32'h0badcafe);
        send(d, k[0], model(d, k[0]));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(W'(32'h5a5a5a5a + k), 1'b0, model(W'(32'h5a5a5a5a + k), 1'b0));
    @(negedge clk);
    check("pt_full_in_ready", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    in_data = 32'hC3C3C3C3;
    in_mode = 1'b1;
    exp_in = model(32'hC3C3C3C3, 1'b1);
    in_valid = 1'b1;
    @(negedge clk);
    check("pt_in_ready", in_ready, 1);
    check("pt_out_valid", out_valid, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("pt_still_full", in_ready, 0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send(W'(32'h01234567 << k), 1'b1, model(W'(32'h01234567 << k), 1'b1));
    #3;
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_data", out_data, 0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk_lat = 1'b1;
    send(32'h00000000, 1'b0, 32'h63636363);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/aes_sbox_pipe.md
Name: aes_sbox_pipe

Overview:
Pipelined AES byte-substitution unit. It accepts a word of LANES bytes per cycle and returns SubBytes results (encrypt) or InvSubBytes results (decrypt) for every byte. Internally it computes the GF(2^8) inverse in the composite field GF(((2^2)^2)^2), built from the team's GF(2^2) and GF(2^4) primitives, including the GF(2^2) scale-square. It sits between the round-state register and ShiftRows, and is shared with the key-expansion SubWord path. It uses a 3-stage valid/ready pipeline with full backpressure.

Parameters:
LANES, 4, number of independent byte lanes processed in parallel (1..16)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input word present
in_ready  out  1  unit can accept input this cycle
in_mode  in  1  0 = SubBytes (encrypt), 1 = InvSubBytes (decrypt); sampled with in_data
in_data  in  8*LANES  input bytes; lane i = bits [8i+7:8i]
out_valid  out  1  output word present
out_ready  in  1  downstream accepts output this cycle
out_mode  out  1  mode that travelled with this word
out_data  out  8*LANES  substituted bytes, lane order preserved

Behaviour:
- Reset
  - Assertion of rst_n=0 is asynchronous. All stage valid flags clear, out_valid=0, out_data=0, out_mode=0.
  - in_ready is 1 in the first cycle after reset release.
  - Reset mid-operation discards all in-flight words. No partial output is produced.
- Transfers
  - An input transfer occurs when in_valid & in_ready at a clk edge.
  - An output transfer occurs when out_valid & out_ready.
  - in_data and in_mode are captured only on an input transfer.
- Pipeline stages. Each stage has a valid flag, and mode is carried in every stage.
  - S1: if mode=1, apply the inverse affine transform. Map the byte to the composite basis. Compute the GF(2^4) operand: (hi+lo)^2 scaled by the field constant, XOR hi*lo.
  - S2: GF(2^4) inverse of the S1 operand. Carry the hi/lo halves forward.
  - S3 (output register): multiply both halves by the inverse, map back to the standard basis, and apply the forward affine transform (x -> A*x + 0x63) if mode=0.
  - The inverse of 0x00 is defined as 0x00.
- Latency and throughput
  - Latency is exactly 3 cycles from input transfer to out_valid when out_ready is held at 1.
  - Throughput is 1 word per cycle sustained.
- Advance rule
  - Stage k loads when stage k is empty, or when stage k drains in the same cycle.
  - S3 drains when out_valid & out_ready.
  - in_ready = !S1.valid | S1 advances. in_ready is combinational from out_ready through the stage valids; no other combinational in->out path exists.
- Stalls
  - While out_ready=0 and S3 is valid, out_data and out_mode hold stable.
  - Upstream stages keep filling until all 3 are full; then in_ready=0.
  - No word is dropped or duplicated.
- Simultaneous events
  - When the pipeline is full and out_ready=1, in_valid=1 is accepted in the same cycle (in_ready=1).
- Mode switching
  - Mode may change on every word. Words of different mode interleave with no bubble.
- Lanes
  - Lanes are fully independent and share control.
  - Each byte result is bit-exact to the FIPS-197 S-box or inverse S-box table.

Test Plan:
- Reset/idle: hold rst_n=0 with in_valid=1 -> out_valid=0, out_data=0. Release rst_n -> in_ready=1, no output until 3 cycles after the first transfer.
- Known vectors, LANES=4, mode=0: in_data=0xFF015300 -> out_data=0x167CED63 exactly 3 cycles later. With mode=1 and in_data=0x167CED63 -> out_data=0xFF015300.
- Exhaustive: stream all 256 byte values (replicated per lane) back-to-back in both modes, with out_ready=1. Required: one output per cycle, each matching the FIPS-197 table, order preserved, mode interleaved every word.
- Backpressure: stream 10 words, hold out_ready=0 for cycles 4..8 -> in_ready drops after 3 words are buffered. out_data is stable while stalled. All 10 results arrive in order with none lost or duplicated.
- Full-pipeline pass-through: with the pipeline full and out_ready=1 plus in_valid=1 in the same cycle -> one word out and one word in that cycle, and occupancy stays at 3.
- Mid-stream reset: assert rst_n=0 asynchronously between clock edges with 3 words in flight -> out_valid falls immediately. After release no stale words appear, and the next input 0x00 (mode 0) yields 0x63 per lane.
